// File: rtl/fetch_unit.sv
// Fetch stage: owns the program counter, addresses instruction memory and
// registers the fetched instruction/PC pair for the read stage.
module fetch_unit #(
    parameter int unsigned            ADDRESS_SIZE     = 10,
    parameter int unsigned            INSTRUCTION_SIZE = 16,
    parameter int unsigned            OPCODE_SIZE      = 7,
    parameter logic [OPCODE_SIZE-1:0] NOP_OPCODE       = 7'd0,
    parameter logic [OPCODE_SIZE-1:0] HALT_OPCODE      = 7'd1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        jump,
    input  logic [ADDRESS_SIZE-1:0]     jump_address,
    input  logic [INSTRUCTION_SIZE-1:0] memory_data,
    output logic [ADDRESS_SIZE-1:0]     memory_address,
    output logic [ADDRESS_SIZE-1:0]     pc,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic                        halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0]     PC_ONE = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [INSTRUCTION_SIZE-1:0] BUBBLE = {INSTRUCTION_SIZE{1'b0}};

    state_t                        r_state;
    logic [ADDRESS_SIZE-1:0]       r_fetch_pc;
    logic [ADDRESS_SIZE-1:0]       r_pc;
    logic [INSTRUCTION_SIZE-1:0]   r_instruction;
    logic                          r_halted;

    logic [OPCODE_SIZE-1:0]        w_opcode;
    logic                          w_is_halt;
    logic [ADDRESS_SIZE-1:0]       w_pc_next;

    assign w_opcode  = memory_data[INSTRUCTION_SIZE-1 -: OPCODE_SIZE];
    assign w_is_halt = (w_opcode == HALT_OPCODE);
    assign w_pc_next = r_fetch_pc + PC_ONE;

    // PC, fetch/read pipeline registers and RUN/HALTED control; jump beats stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= {ADDRESS_SIZE{1'b0}};
            r_pc          <= {ADDRESS_SIZE{1'b0}};
            r_instruction <= BUBBLE;
            r_halted      <= 1'b0;
        end else if (jump) begin
            // A stall may belong to a wrong-path instruction, so it must not block the redirect.
            r_state       <= ST_RUN;
            r_fetch_pc    <= jump_address;
            r_pc          <= {ADDRESS_SIZE{1'b0}};
            r_instruction <= BUBBLE;
            r_halted      <= 1'b0;
        end else if (stall) begin
            r_state       <= r_state;
            r_fetch_pc    <= r_fetch_pc;
            r_pc          <= r_pc;
            r_instruction <= r_instruction;
            r_halted      <= r_halted;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_pc          <= r_fetch_pc;
                    r_instruction <= memory_data;
                    if (w_is_halt) begin
                        r_fetch_pc <= r_fetch_pc;
                        r_state    <= ST_HALTED;
                        r_halted   <= 1'b1;
                    end else begin
                        r_fetch_pc <= w_pc_next;
                        r_state    <= ST_RUN;
                        r_halted   <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    r_fetch_pc    <= r_fetch_pc;
                    r_pc          <= {ADDRESS_SIZE{1'b0}};
                    r_instruction <= BUBBLE;
                    r_state       <= ST_HALTED;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_fetch_pc    <= {ADDRESS_SIZE{1'b0}};
                    r_pc          <= {ADDRESS_SIZE{1'b0}};
                    r_instruction <= BUBBLE;
                    r_state       <= ST_RUN;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign memory_address = r_fetch_pc;
    assign pc             = r_pc;
    assign instruction    = r_instruction;
    assign halted         = r_halted;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Pipeline stage 1: holds the program counter and drives the instruction-memory address.
- Registers the fetched instruction and its PC into the fetch/read pipeline registers consumed by the read stage.
- Handles stall (hold), jump (redirect plus one-bubble flush) and HALT (freeze fetch until redirected or reset).

Parameters:
- ADDRESS_SIZE, 10, width of program counter and instruction-memory address.
- INSTRUCTION_SIZE, 16, instruction word width.
- OPCODE_SIZE, 7, opcode field width; opcode = instruction[INSTRUCTION_SIZE-1 -: OPCODE_SIZE].
- NOP_OPCODE, 7'd0, opcode inserted as a bubble; the bubble instruction word is all zeros.
- HALT_OPCODE, 7'd1, opcode that stops fetching.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold request from the hazard logic.
- jump  input  1  redirect request from the execute stage.
- jump_address  input  ADDRESS_SIZE  redirect target, valid when jump=1.
- memory_data  input  INSTRUCTION_SIZE  instruction-memory read data; combinational read of memory_address.
- memory_address  output  ADDRESS_SIZE  current PC register, driven combinationally from the PC.
- pc  output  ADDRESS_SIZE  registered PC of the instruction presented to the read stage.
- instruction  output  INSTRUCTION_SIZE  registered instruction presented to the read stage.
- halted  output  1  registered; 1 while the FSM is in HALTED.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0, pc=0, instruction=0 (NOP), state=RUN, halted=0.
  - Reset mid-operation discards everything and fetching restarts at address 0 on the first rising edge after release.
- State machine: two states, RUN and HALTED. halted mirrors state==HALTED, registered.
- Per rising edge, priority is jump > stall > normal:
  - jump=1, any state, stall ignored:
    - PC<=jump_address; instruction<=0; pc<=0; state<=RUN.
    - The instruction on memory_data this cycle is discarded.
    - The jump target's instruction appears at the outputs one edge later.
  - jump=0, stall=1: PC, pc, instruction and state all hold their values.
  - RUN, no jump, no stall:
    - pc<=PC; instruction<=memory_data.
    - If memory_data opcode==HALT_OPCODE: PC holds and state<=HALTED. The HALT instruction itself is still passed to the read stage.
    - Otherwise PC<=PC+1.
  - HALTED, no jump, no stall: PC holds; instruction<=0; pc<=0. The FSM stays in HALTED until jump or reset.
- Latency: the instruction at address A appears on instruction/pc exactly one edge after PC==A, absent stall/jump. Throughput is 1 instruction per cycle.
- Arithmetic: PC+1 is modulo 2^ADDRESS_SIZE, so PC=2^ADDRESS_SIZE-1 wraps to 0 with no flag. jump_address is used unmodified.
- Simultaneous events:
  - jump with stall: the jump wins, because a stall on a wrong-path instruction must not block the redirect.
  - jump in the same cycle a HALT is fetched: the jump wins. The HALT is discarded and the FSM stays in RUN.
- No combinational path from stall or jump to any output except through registers. memory_address depends on the PC register only.

Test Plan:
1. Reset release, memory holding opcodes ADD at 0..3 -> memory_address goes 0,1,2,3 on successive edges. pc outputs 0,1,2,3 one cycle later, with instruction matching memory; halted=0.
2. Stall held 2 cycles while PC=5 -> memory_address stays 5, and pc/instruction hold the address-4 values for both cycles. After release, address 5 is delivered on the next edge.
3. jump=1, jump_address=0x040 while PC=7 -> next edge gives instruction=0 and pc=0. The edge after gives pc=0x040 with memory[0x040], and PC=0x041.
4. HALT at address 9 -> instruction=HALT word with pc=9, then halted=1 and PC frozen at 9. Afterwards instruction=0 on every edge for 10+ cycles.
5. In HALTED, jump=1 with jump_address=0x010 and stall=1 simultaneously -> halted=0 after the edge and a bubble is inserted. Fetching resumes at 0x010.
6. PC=0x3FF (ADDRESS_SIZE=10), no stall/jump -> pc=0x3FF is delivered and PC wraps to 0x000. Then assert reset mid-run -> all outputs are 0 immediately, and fetching restarts at 0 after release.
